reg_bank_drain: RTL and testbench

//  Read side of the accumulator register bank. On start, streams all DEPTH WIDTH-bit registers out
//  in index order (0..DEPTH-1) over a valid/ready interface, then pulses done.

---
 rtl/aggr_pkg.sv | 25 ++
 rtl/register.sv | 41 ++++
 rtl/reg_bank_drain.sv | 188 ++++++++++++++++++
 tb/tb_reg_bank_drain.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aggr_pkg.sv
// ---------------------------------------------------------------------------
// aggr_pkg
//  Shared definitions for the aggregation datapath: accumulator width, the
//  drain FSM state encoding and a helper that derives a minimum-1 index width.
// ---------------------------------------------------------------------------
package aggr_pkg;

  // Default width of one accumulator register entry.
  localparam int ACC_WIDTH = 20;

  // Drain FSM encoding. DR_LOAD is kept in the encoding even though the
  // normal drain path goes straight from DR_IDLE to DR_SEND.
  typedef enum logic [1:0] {
    DR_IDLE = 2'd0,
    DR_LOAD = 2'd1,
    DR_SEND = 2'd2,
    DR_DONE = 2'd3
  } drain_state_t;

  // Index width for a bank of 'depth' entries, never less than one bit.
  function automatic int idx_width(input int depth);
    return ($clog2(depth) > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/register.sv
// ---------------------------------------------------------------------------
// register
//  Generic load-enabled holding register with asynchronous active-low reset.
//  Ports:
//    clk     in   rising-edge clock
//    arst_n  in   asynchronous reset, active-low (clears q to zero)
//    we      in   load strobe; d is captured on the rising edge when high
//    d       in   WIDTH-bit data to load
//    q       out  WIDTH-bit registered value
// ---------------------------------------------------------------------------
module register #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (we) begin
      q_d = d;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/reg_bank_drain.sv
// ---------------------------------------------------------------------------
// reg_bank_drain
//  Read side of the accumulator register bank. A start pulse in IDLE streams
//  all DEPTH entries out in index order over a valid/ready interface, one beat
//  per cycle when the consumer is ready, then pulses done for one cycle.
//  Each entry is sampled from bank_q on the edge it is loaded into the output
//  holding register; later bank changes to that entry are not reflected.
//
//  Ports:
//    clk        in   rising-edge clock
//    arst_n     in   asynchronous reset, active-low
//    start      in   begin a drain (only honoured in IDLE)
//    bank_q     in   flattened bank, entry i at [i*WIDTH +: WIDTH]
//    rd_clr     out  per-entry clear strobe toward the bank
//    out_data   out  entry value
//    out_idx    out  entry index of out_data
//    out_last   out  high when out_idx == DEPTH-1
//    out_valid  out  out_* holds a valid beat
//    out_ready  in   consumer accepts when out_valid && out_ready
//    busy       out  high while a drain is streaming
//    done       out  one-cycle pulse after the last beat is accepted
//
//  Build option (macro CLEAR_ON_READ_EN):
//    defined   : rd_clr[i] is a combinational strobe asserted on the cycle
//                entry i is accepted, so the bank clears it on that edge.
//    undefined : rd_clr is tied low and drains leave the bank untouched.
// ---------------------------------------------------------------------------
module reg_bank_drain
  import aggr_pkg::*;
#(
  parameter int WIDTH = ACC_WIDTH,
  parameter int DEPTH = 8,
  parameter int IDX_W = idx_width(DEPTH)
) (
  input  logic                   clk,
  input  logic                   arst_n,
  input  logic                   start,
  input  logic [DEPTH*WIDTH-1:0] bank_q,
  output logic [DEPTH-1:0]       rd_clr,
  output logic [WIDTH-1:0]       out_data,
  output logic [IDX_W-1:0]       out_idx,
  output logic                   out_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   done
);

  localparam int               HOLD_W   = WIDTH + IDX_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  // Unpacked view of the bank for the read mux.
  logic [WIDTH-1:0] bank_arr [DEPTH];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_unpack
      assign bank_arr[gi] = bank_q[gi*WIDTH +: WIDTH];
    end
  endgenerate

  drain_state_t state_q, state_d;
  logic         valid_q, valid_d;
  logic         busy_q,  busy_d;
  logic         done_q,  done_d;

  logic             load_we;
  logic [IDX_W-1:0] load_idx;
  logic [WIDTH-1:0] load_data;
  logic [HOLD_W-1:0] hold_d;
  logic [HOLD_W-1:0] hold_q;

  logic [WIDTH-1:0] hold_data;
  logic [IDX_W-1:0] hold_idx;
  logic             hold_last;
  logic             accept;

  assign {hold_last, hold_idx, hold_data} = hold_q;
  assign accept = valid_q && out_ready;

  // Next-state / load control. The index counter lives in the holding
  // register itself: the next entry to load is always current index + 1,
  // and a new drain always restarts from entry 0.
  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    load_we  = 1'b0;
    load_idx = '0;
    case (state_q)
      DR_IDLE: begin
        if (start) begin
          load_we  = 1'b1;
          load_idx = '0;
          valid_d  = 1'b1;
          busy_d   = 1'b1;
          state_d  = DR_SEND;
        end
      end
      DR_LOAD: begin
        // Not entered by the normal drain flow; if ever reached it restarts
        // the stream cleanly from entry 0.
        load_we  = 1'b1;
        load_idx = '0;
        valid_d  = 1'b1;
        busy_d   = 1'b1;
        state_d  = DR_SEND;
      end
      DR_SEND: begin
        if (accept) begin
          if (hold_last) begin
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DR_DONE;
          end else begin
            // Reload on the accepting edge for one beat per cycle.
            load_we  = 1'b1;
            load_idx = hold_idx + 1'b1;
          end
        end
      end
      DR_DONE: begin
        state_d = DR_IDLE;
      end
      default: begin
        state_d = DR_IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Bank read mux; compare-based so any DEPTH (including 1) indexes safely.
  always_comb begin
    load_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (load_idx == IDX_W'(i)) begin
        load_data = bank_arr[i];
      end
    end
  end

  assign hold_d = {(load_idx == LAST_IDX), load_idx, load_data};

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= DR_IDLE;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Output holding register: {last, idx, data}.
  register #(
    .WIDTH (HOLD_W)
  ) u_hold (
    .clk    (clk),
    .arst_n (arst_n),
    .we     (load_we),
    .d      (hold_d),
    .q      (hold_q)
  );

  assign out_data  = hold_data;
  assign out_idx   = hold_idx;
  assign out_last  = hold_last;
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

`ifdef CLEAR_ON_READ_EN
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_clr
      assign rd_clr[gi] = accept && (hold_idx == IDX_W'(gi));
    end
  endgenerate
`else
  assign rd_clr = '0;
`endif

endmodule

// File: tb/tb_reg_bank_drain.sv
module tb_reg_bank_drain;

  localparam int WIDTH = 20;
  localparam int DEPTH = 8;
  localparam int IDX_W = 3;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  logic start = 1'b0;
  logic out_ready = 1'b0;
  logic [WIDTH-1:0] bank_arr [DEPTH];
  logic [DEPTH*WIDTH-1:0] bank_q;
  logic [DEPTH-1:0] rd_clr;
  logic [WIDTH-1:0] out_data;
  logic [IDX_W-1:0] out_idx;
  logic out_last, out_valid, busy, done;

  // Single-entry instance.
  logic start1 = 1'b0;
  logic out_ready1 = 1'b0;
  logic [WIDTH-1:0] bank1 = '0;
  logic [0:0] rd_clr1;
  logic [WIDTH-1:0] out_data1;
  logic [0:0] out_idx1;
  logic out_last1, out_valid1, busy1, done1;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) bank_q[i*WIDTH +: WIDTH] = bank_arr[i];
  end

  reg_bank_drain #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .arst_n(arst_n), .start(start), .bank_q(bank_q), .rd_clr(rd_clr),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  reg_bank_drain #(.WIDTH(WIDTH), .DEPTH(1)) dut1 (
    .clk(clk), .arst_n(arst_n), .start(start1), .bank_q(bank1), .rd_clr(rd_clr1),
    .out_data(out_data1), .out_idx(out_idx1), .out_last(out_last1), .out_valid(out_valid1),
    .out_ready(out_ready1), .busy(busy1), .done(done1)
  );

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Behavioural model: phase 0 = idle, 1 = streaming beat m_idx, 2 = done cycle.
  int m_phase = 0;
  int m_idx = 0;
  logic [WIDTH-1:0] m_data = '0;

  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      m_phase = 0;
      m_idx = 0;
      m_data = '0;
    end else begin
      if (m_phase == 0) begin
        if (start) begin
          m_phase = 1;
          m_idx = 0;
          m_data = bank_arr[0];
        end
      end else if (m_phase == 1) begin
        if (out_ready) begin
          if (m_idx == DEPTH - 1) m_phase = 2;
          else begin
            m_idx = m_idx + 1;
            m_data = bank_arr[m_idx];
          end
        end
      end else begin
        m_phase = 0;
      end
    end
  end

  // Compare process: every falling edge.
  always @(negedge clk) begin
    logic [DEPTH-1:0] exp_clr;
    exp_clr = '0;
    if (arst_n) begin
      check("valid", out_valid, m_phase == 1);
      check("busy", busy, m_phase == 1);
      check("done", done, m_phase == 2);
      if (m_phase == 1) begin
        check("idx", out_idx, m_idx);
        check("data", out_data, m_data);
        check("last", out_last, m_idx == DEPTH - 1);
`ifdef CLEAR_ON_READ_EN
        if (out_ready) exp_clr[m_idx] = 1'b1;
`endif
      end
      check("rd_clr", rd_clr, exp_clr);
    end else begin
      check("rst_outs", {out_valid, busy, done, out_last, out_idx, out_data, rd_clr}, 0);
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  int done_cnt = 0;
  int acc_data[$];
  int acc_cyc[$];
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (arst_n && out_valid && out_ready) begin
      acc_data.push_back(int'(out_data));
      acc_cyc.push_back(cyc);
    end
  end

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || done) && n < budget);
    if (busy || done) check("idle_timeout", busy | done, 0);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int d0, stall, seen;
    for (int i = 0; i < DEPTH; i++) bank_arr[i] = '0;
    repeat (3) @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_data", out_data, 0);
    check("rst_clr", rd_clr, 0);
    #1 arst_n = 1'b1;

    // Full-rate drain.
    for (int i = 0; i < DEPTH; i++) bank_arr[i] = WIDTH'(i * 3 + 1);
    out_ready = 1'b1;
    acc_data.delete();
    acc_cyc.delete();
    d0 = done_cnt;
    @(negedge clk); #1 start = 1'b1;
    @(negedge clk);
    check("lat_valid", out_valid, 1);
    check("lat_idx", out_idx, 0);
    check("lat_busy", busy, 1);
    #1 start = 1'b0;
    wait_idle(40);
    check("fr_beats", acc_data.size(), 8);
    for (int i = 0; i < acc_data.size(); i++) check($sformatf("fr_beat%0d", i), acc_data[i], i * 3 + 1);
    if (acc_cyc.size() == 8) check("fr_consec", acc_cyc[7] - acc_cyc[0], 7);
    check("fr_done_cnt", done_cnt - d0, 1);

    // Backpressure at index 2.
    for (int i = 0; i < DEPTH; i++) bank_arr[i] = WIDTH'($urandom);
    bank_arr[2] = 20'd7;
    out_ready = 1'b1;
    stall = 0;
    d0 = done_cnt;
    @(negedge clk); #1 start = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (out_valid && out_idx == 2 && stall > 0) begin
        check("bp_data", out_data, 7);
        check("bp_idx", out_idx, 2);
      end
`ifdef CLEAR_ON_READ_EN
      if (out_valid && out_ready && out_idx == 2) check("clr_idx2", rd_clr, 8'h04);
`endif
      if (c > 0 && !busy && !done) break;
      #1 start = 1'b0;
      if (out_valid && out_idx == 2 && stall < 3) begin
        out_ready = 1'b0;
        stall++;
        bank_arr[2] = 20'd9;
      end else out_ready = 1'b1;
    end
    #1 start = 1'b0;
    check("bp_stalls", stall, 3);
    check("bp_done_cnt", done_cnt - d0, 1);

    // Stale starts at idx 4 and in DONE.
    out_ready = 1'b1;
    d0 = done_cnt;
    seen = 0;
    @(negedge clk); #1 start = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (seen && !done) break;
      #1 start = 1'b0;
      if (out_valid && out_idx == 4) start = 1'b1;
      if (done) begin
        start = 1'b1;
        seen = 1;
      end
    end
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    check("stale_norestart", busy, 0);
    check("stale_done_cnt", done_cnt - d0, 1);
    #1;

    // Randomized drains.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < DEPTH; i++) bank_arr[i] = WIDTH'($urandom);
      d0 = done_cnt;
      @(negedge clk); #1 start = 1'b1;
      for (int c = 0; c < 300; c++) begin
        @(negedge clk);
        if (c > 0 && !busy && !done) break;
        #1;
        start = ($urandom_range(0, 7) == 0);
        out_ready = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 3) == 0) bank_arr[$urandom_range(0, DEPTH - 1)] = WIDTH'($urandom);
      end
      #1 start = 1'b0;
      check("rand_finish", busy, 0);
      check("rand_done_cnt", done_cnt - d0, 1);
    end

    // Reset mid-drain.
    for (int i = 0; i < DEPTH; i++) bank_arr[i] = WIDTH'(i + 100);
    out_ready = 1'b1;
    @(negedge clk); #1 start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (out_idx == 3) break;
    end
    check("rst_mid_seen", out_idx, 3);
    d0 = done_cnt;
    #1 arst_n = 1'b0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_data", out_data, 0);
    check("arst_idx", out_idx, 0);
    check("arst_clr", rd_clr, 0);
    repeat (2) @(negedge clk);
    #1 arst_n = 1'b1;
    check("arst_nodone", done_cnt - d0, 0);
    @(negedge clk); #1 start = 1'b1;
    @(negedge clk);
    check("restart_valid", out_valid, 1);
    check("restart_idx", out_idx, 0);
    check("restart_data", out_data, 100);
    #1 start = 1'b0;
    wait_idle(40);

    // Single-entry bank.
    bank1 = 20'hABCDE;
    out_ready1 = 1'b1;
    @(negedge clk); #1 start1 = 1'b1;
    @(negedge clk);
    check("d1_valid", out_valid1, 1);
    check("d1_last", out_last1, 1);
    check("d1_idx", out_idx1, 0);
    check("d1_data", out_data1, 20'hABCDE);
    check("d1_busy", busy1, 1);
`ifdef CLEAR_ON_READ_EN
    check("d1_clr", rd_clr1, 1);
`else
    check("d1_clr", rd_clr1, 0);
`endif
    #1 start1 = 1'b0;
    @(negedge clk);
    check("d1_valid_off", out_valid1, 0);
    check("d1_done", done1, 1);
    @(negedge clk);
    check("d1_done_off", done1, 0);
    check("d1_idle", busy1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
